// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage registers.
// Provides the stage state encoding, occupancy width, CPU default field
// widths and the named control-bit positions used by downstream stages.
package pipe_pkg;

  localparam int unsigned OCC_W      = 2;
  localparam int unsigned DEF_CTRL_W = 4;
  localparam int unsigned DEF_TAG_W  = 5;
  localparam int unsigned DEF_DATA_W = 64;

  // Control-bit positions inside the ctrl field
  localparam int unsigned CTRL_MEMREAD  = 0;
  localparam int unsigned CTRL_MEMWRITE = 1;
  localparam int unsigned CTRL_MEMTOREG = 2;
  localparam int unsigned CTRL_REGWRITE = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } pipe_state_t;

  // Number of entries held in a given state
  function automatic logic [OCC_W-1:0] state_occ(input pipe_state_t s);
    logic [OCC_W-1:0] occ;
    occ = '0;
    case (s)
      EMPTY:   occ = OCC_W'(0);
      BUSY:    occ = OCC_W'(1);
      FULL:    occ = OCC_W'(2);
      default: occ = OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One enable-loaded entry register holding {ctrl, tag, data}.
// Ports: clk, rst (sync, active-high, clears to 0), load (capture next_*),
//        next_ctrl/next_tag/next_data (entry to capture),
//        ctrl/tag/data (held entry).
import pipe_pkg::*;

module pipe_slot #(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned TAG_W  = DEF_TAG_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [CTRL_W-1:0] next_ctrl,
  input  logic [TAG_W-1:0]  next_tag,
  input  logic [DATA_W-1:0] next_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] data
);

  // Entry storage; holds its value whenever load is low
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
      tag  <= '0;
      data <= '0;
    end else if (load) begin
      ctrl <= next_ctrl;
      tag  <= next_tag;
      data <= next_data;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready flow control, flush and an
// optional second (skid) slot.
// Build option: PIPE_STAGE_SKID_EN
//   defined   - two slots (main + skid), in_ready comes straight from a flop
//   undefined - single slot, in_ready = !out_valid | out_ready
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       drop held entries and the incoming one
//   in_valid/in_ready           upstream handshake
//   in_ctrl/in_data/in_tag      incoming entry
//   out_valid/out_ready         downstream handshake
//   out_ctrl                    control bits, zero while out_valid=0
//   out_data/out_tag            held entry payload and destination register
//   occupancy                   entries held (0..2)
import pipe_pkg::*;

module pipe_stage_skid #(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned TAG_W  = DEF_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [OCC_W-1:0]  occupancy
);

  pipe_state_t state, next_state;

  logic              xfer_in, xfer_out;
  logic              load_main;
  logic              out_valid_q;
  logic [OCC_W-1:0]  occupancy_q;
  logic [CTRL_W-1:0] main_ctrl, main_next_ctrl;
  logic [TAG_W-1:0]  main_tag, main_next_tag;
  logic [DATA_W-1:0] main_data, main_next_data;

`ifdef PIPE_STAGE_SKID_EN
  logic              load_skid;
  logic              main_from_skid;
  logic              in_ready_q;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [TAG_W-1:0]  skid_tag;
  logic [DATA_W-1:0] skid_data;
`endif

  assign xfer_in  = in_valid & in_ready;
  assign xfer_out = out_valid & out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= next_state;
    end
  end

  // Next state and slot load controls; flush drops everything, including
  // an entry that is handshaking in the same cycle
  always_comb begin
    next_state = state;
    load_main  = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
`endif
    if (flush) begin
      next_state = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            next_state = BUSY;
            load_main  = 1'b1;
          end
        end
        BUSY: begin
          if (xfer_in && xfer_out) begin
            load_main = 1'b1;
          end else if (xfer_in) begin
`ifdef PIPE_STAGE_SKID_EN
            next_state = FULL;
            load_skid  = 1'b1;
`else
            // Unreachable: in BUSY in_ready follows out_ready
            next_state = BUSY;
`endif
          end else if (xfer_out) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
`ifdef PIPE_STAGE_SKID_EN
          if (out_ready) begin
            next_state     = BUSY;
            load_main      = 1'b1;
            main_from_skid = 1'b1;
          end
`else
          next_state = EMPTY;
`endif
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  // Status flags registered from the next state so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      occupancy_q <= '0;
    end else begin
      out_valid_q <= (next_state != EMPTY);
      occupancy_q <= state_occ(next_state);
    end
  end

`ifdef PIPE_STAGE_SKID_EN
  // in_ready depends only on held state, never on out_ready
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_q <= 1'b1;
    end else begin
      in_ready_q <= (next_state != FULL);
    end
  end

  assign in_ready       = in_ready_q;
  assign main_next_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_next_tag  = main_from_skid ? skid_tag  : in_tag;
  assign main_next_data = main_from_skid ? skid_data : in_data;

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load      (load_skid),
    .next_ctrl (in_ctrl),
    .next_tag  (in_tag),
    .next_data (in_data),
    .ctrl      (skid_ctrl),
    .tag       (skid_tag),
    .data      (skid_data)
  );
`else
  assign in_ready       = ~out_valid | out_ready;
  assign main_next_ctrl = in_ctrl;
  assign main_next_tag  = in_tag;
  assign main_next_data = in_data;
`endif

  pipe_slot #(
    .CTRL_W (CTRL_W),
    .TAG_W  (TAG_W),
    .DATA_W (DATA_W)
  ) u_main (
    .clk       (clk),
    .rst       (rst),
    .load      (load_main),
    .next_ctrl (main_next_ctrl),
    .next_tag  (main_next_tag),
    .next_data (main_next_data),
    .ctrl      (main_ctrl),
    .tag       (main_tag),
    .data      (main_data)
  );

  assign out_valid = out_valid_q;
  assign occupancy = occupancy_q;
  // Invalid slots never present asserted control bits downstream
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid_q}};
  assign out_data  = main_data;
  assign out_tag   = main_tag;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid (either build of PIPE_STAGE_SKID_EN).
// A queue model of the stage is compared against the DUT on every falling
// edge; directed phases add hand-computed literal expectations.
module tb_pipe_stage_skid;

`ifdef PIPE_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  typedef struct packed {
    logic [3:0]  ctrl;
    logic [4:0]  tag;
    logic [63:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_ctrl = '0;
  logic [63:0] in_data = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  out_ctrl;
  logic [63:0] out_data;
  logic [4:0]  out_tag;
  logic [1:0]  occupancy;

  int   checks = 0;
  int   errors = 0;
  int   delivered = 0;
  bit   seen9 = 1'b0;
  bit   chk_en = 1'b0;
  ent_t pending[$];
  ent_t mq[$];

  pipe_stage_skid dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_in_ready();
    if (SKID) return (mq.size() < 2);
    return (mq.size() == 0) || (out_ready == 1'b1);
  endfunction

  function automatic ent_t mk(input int tag, input logic [63:0] data, input logic [3:0] ctrl);
    ent_t e;
    e.ctrl = ctrl;
    e.tag  = 5'(tag);
    e.data = data;
    return e;
  endfunction

  // Driver: present the head of the pending list to the stage
  always @(posedge clk) begin
    #2;
    if (pending.size() > 0) begin
      in_valid = 1'b1;
      in_ctrl  = pending[0].ctrl;
      in_tag   = pending[0].tag;
      in_data  = pending[0].data;
    end else begin
      in_valid = 1'b0;
    end
  end

  // Model: a FIFO of capacity 2 (skid) or 1 (single slot); reset and flush
  // empty it, an entry handshaking in during flush or reset is lost
  always @(posedge clk) begin
    bit mv, mr;
    mv = (mq.size() > 0);
    mr = m_in_ready();
    if (in_valid && mr && pending.size() > 0) void'(pending.pop_front());
    if (rst || flush) begin
      mq.delete();
    end else begin
      if (mv && out_ready) void'(mq.pop_front());
      if (in_valid && mr) mq.push_back(mk(int'(in_tag), in_data, in_ctrl));
    end
  end

  // Compare DUT against model every cycle
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (mq.size() > 0);
      check("m_out_valid", 64'(out_valid), 64'(ev));
      check("m_in_ready", 64'(in_ready), 64'(m_in_ready()));
      check("m_occupancy", 64'(occupancy), 64'(mq.size()));
      check("m_out_ctrl", 64'(out_ctrl), ev ? 64'(mq[0].ctrl) : 64'(0));
      if (ev) begin
        check("m_out_tag", 64'(out_tag), 64'(mq[0].tag));
        check("m_out_data", out_data, mq[0].data);
      end
      if (out_valid && out_tag == 5'd9) seen9 = 1'b1;
      if (out_valid && out_ready && !rst && !flush) delivered++;
    end
  end

  task automatic check_reset_values(input string tagname);
    check({tagname, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tagname, "_out_ctrl"}, 64'(out_ctrl), 64'(0));
    check({tagname, "_in_ready"}, 64'(in_ready), 64'(1));
    check({tagname, "_occupancy"}, 64'(occupancy), 64'(0));
    check({tagname, "_out_data"}, out_data, 64'(0));
    check({tagname, "_out_tag"}, 64'(out_tag), 64'(0));
  endtask

  initial begin
    logic [15:0] pat;
    int n;
    pat = 16'b1011_0010_1110_0101;

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check_reset_values("reset");

    // Streaming: tags 1..8 back to back, out_ready held high
    @(posedge clk);
    #1 out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) pending.push_back(mk(k, 64'(k * 16), 4'b1001));
    @(posedge clk);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("stream_valid", 64'(out_valid), 64'(1));
      check("stream_tag", 64'(out_tag), 64'(k));
      check("stream_data", out_data, 64'(k * 16));
      if (k == 1) check("stream_ctrl", 64'(out_ctrl), 64'(4'b1001));
    end

    // Stall: tag 3 then tag 4 with out_ready low
    @(posedge clk);
    #1 out_ready = 1'b0;
    pending.push_back(mk(3, 64'h33, 4'b0101));
    pending.push_back(mk(4, 64'h44, 4'b0110));
    @(posedge clk);
    @(negedge clk);
    check("stall_tag_a", 64'(out_tag), 64'(3));
    check("stall_in_ready_a", 64'(in_ready), SKID ? 64'(1) : 64'(0));
    @(posedge clk);
    @(negedge clk);
    check("stall_tag_b", 64'(out_tag), 64'(3));
    check("stall_occ", 64'(occupancy), SKID ? 64'(2) : 64'(1));
    check("stall_in_ready_b", 64'(in_ready), 64'(0));
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stall_tag_hold", 64'(out_tag), 64'(3));
    check("stall_data_hold", out_data, 64'h33);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    check("release_tag3", 64'(out_tag), 64'(3));
    @(negedge clk);
    check("release_tag4", 64'(out_tag), 64'(4));
    check("release_ctrl4", 64'(out_ctrl), 64'(4'b0110));
    @(negedge clk);
    check("release_empty", 64'(out_valid), 64'(0));

    // Flush while full (single-slot build: busy with tag 6 waiting)
    @(posedge clk);
    #1 out_ready = 1'b0;
    pending.push_back(mk(5, 64'h55, 4'b1111));
    pending.push_back(mk(6, 64'h66, 4'b1111));
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    pending.delete();
    pending.push_back(mk(9, 64'h99, 4'b1111));
    @(posedge clk);
    #1 flush = 1'b0;
    pending.delete();
    @(negedge clk);
    check("flushfull_valid", 64'(out_valid), 64'(0));
    check("flushfull_ctrl", 64'(out_ctrl), 64'(0));
    check("flushfull_occ", 64'(occupancy), 64'(0));
    check("flushfull_in_ready", 64'(in_ready), 64'(1));

    // Flush while busy with in_ready high: incoming tag 9 still dropped
    @(posedge clk);
    #1 pending.push_back(mk(7, 64'h77, 4'b1000));
    @(posedge clk);
    #1 flush = 1'b1;
    out_ready = 1'b1;
    pending.push_back(mk(9, 64'h99, 4'b1111));
    @(posedge clk);
    #1 flush = 1'b0;
    out_ready = 1'b0;
    pending.delete();
    @(negedge clk);
    check("flushbusy_valid", 64'(out_valid), 64'(0));
    check("flushbusy_occ", 64'(occupancy), 64'(0));

    // Reset mid-stream together with flush and an incoming entry
    @(posedge clk);
    #1 pending.push_back(mk(10, 64'hAA, 4'b0011));
    pending.push_back(mk(11, 64'hBB, 4'b0011));
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    flush = 1'b1;
    pending.delete();
    pending.push_back(mk(9, 64'h99, 4'b1111));
    @(posedge clk);
    #1 rst = 1'b0;
    flush = 1'b0;
    pending.delete();
    @(negedge clk);
    check_reset_values("midreset");

    // Mixed traffic with a fixed out_ready pattern
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) pending.push_back(mk(16 + i, {32'(i * 7), 32'hA5A5_0000 | 32'(i)}, 4'(i)));
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1 out_ready = pat[c % 16];
    end
    out_ready = 1'b1;
    n = 0;
    while ((mq.size() > 0 || pending.size() > 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    check("drain_in_time", 64'(n < 100), 64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("delivered_count", 64'(delivered), 64'(26));
    check("tag9_never_seen", 64'(seen9), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
